set_bit_serializer: RTL

// - Decoding counterpart of the priority encoder: accepts a WIDTH-bit word and

---
 rtl/set_bit_ser_pkg.sv | 35 +++
 rtl/onehot_isolate.sv | 15 +
 rtl/set_bit_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/set_bit_ser_pkg.sv
// Shared types and helpers for the set-bit serializer.
// Contents:
//   state_t        - FSM states (IDLE: waiting for a word, ITER: emitting beats)
//   MAX_W          - widest vector the helper functions accept
//   idx_of_onehot  - bit position of a one-hot vector (0 for an all-zero vector)
//   popcount       - number of set bits
// Callers zero-extend their WIDTH-bit vectors to MAX_W and cast the result back.
package set_bit_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  localparam int MAX_W = 32;

  function automatic int idx_of_onehot(input logic [MAX_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/onehot_isolate.sv
// Combinational isolation of the lowest set bit of a mask.
// Ports:
//   i_mask  in   WIDTH  input mask
//   o_bit   out  WIDTH  one-hot lowest set bit of i_mask (all zero if i_mask is zero)
module onehot_isolate #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [WIDTH-1:0] o_bit
);

  // Two's complement trick: only the lowest set bit survives mask & -mask.
  assign o_bit = i_mask & (~i_mask + 1'b1);

endmodule

// File: rtl/set_bit_serializer.sv
// Set-bit serializer: accepts a WIDTH-bit word and emits each set bit as its
// own one-hot beat together with its index, the word popcount and first/last
// flags. One word in flight at a time; valid/ready on both sides.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds its payload stable while valid is high and
// ready is low. data_rdy_o depends on registered state only.
//
// Ports:
//   clk_i       in   1      clock
//   arst_n_i    in   1      asynchronous active-low reset
//   data_i      in   WIDTH  word to serialize
//   data_val_i  in   1      data_i valid
//   data_rdy_o  out  1      block can accept a word (high in IDLE)
//   bit_o       out  WIDTH  one-hot current set bit
//   idx_o       out  IDX_W  position of bit_o
//   cnt_o       out  CNT_W  popcount of the accepted word
//   first_o     out  1      first beat of the word
//   last_o      out  1      last beat of the word
//   val_o       out  1      output beat valid
//   rdy_i       in   1      downstream accepts the beat
//
// Configuration macro: SET_BIT_SER_MSB_FIRST_EN
//   defined   - beats are emitted highest set bit first
//   undefined - beats are emitted lowest set bit first
module set_bit_serializer
  import set_bit_ser_pkg::*;
#(
  parameter int  WIDTH = 5,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] bit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             first_o,
  output logic             last_o,
  output logic             val_o,
  input  logic             rdy_i
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_first;
  logic             w_first_nxt;

  logic [WIDTH-1:0] w_iso_in;
  logic [WIDTH-1:0] w_iso_out;
  logic [WIDTH-1:0] w_bit;
  logic             w_last;
  logic             w_busy;

`ifdef SET_BIT_SER_MSB_FIRST_EN
  // Isolating the lowest bit of the reversed mask yields the highest set bit;
  // reversing back keeps bit_o/idx_o in true bit positions.
  always_comb begin
    w_iso_in = '0;
    w_bit    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_iso_in[i] = r_rem[WIDTH-1-i];
      w_bit[i]    = w_iso_out[WIDTH-1-i];
    end
  end
`else
  assign w_iso_in = r_rem;
  assign w_bit    = w_iso_out;
`endif

  onehot_isolate #(
    .WIDTH(WIDTH)
  ) u_isolate (
    .i_mask(w_iso_in),
    .o_bit (w_iso_out)
  );

  assign w_busy = (r_state == ITER);
  assign w_last = ((r_rem & ~w_bit) == '0);

  // State register plus the datapath registers it controls.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    case (r_state)
      IDLE: begin
        // A zero word is consumed here without leaving IDLE.
        if (data_val_i && (data_i != '0)) begin
          w_state_nxt = ITER;
          w_rem_nxt   = data_i;
          w_cnt_nxt   = CNT_W'(popcount(MAX_W'(data_i)));
          w_first_nxt = 1'b1;
        end
      end
      ITER: begin
        if (rdy_i) begin
          w_rem_nxt   = r_rem & ~w_bit;
          w_first_nxt = 1'b0;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_rdy_o = (r_state == IDLE);
  assign val_o      = w_busy;
  assign bit_o      = w_bit;
  assign idx_o      = IDX_W'(idx_of_onehot(MAX_W'(w_bit)));
  assign cnt_o      = r_cnt;
  assign first_o    = w_busy & r_first;
  assign last_o     = w_busy & w_last;

endmodule
